// File: rtl/dial_pkg.sv
// Shared definitions for the dial zero counter.
//
// Contents:
//   state_t   - controller states (IDLE, REV, STEP)
//   DIR_UP    - step_direction value that moves the dial +1 per step
//   DIR_DOWN  - step_direction value that moves the dial -1 per step
package dial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REV  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/dial_zero_counter_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-low reset
//   inc   in   1      count one event this cycle
//   count out  WIDTH  number of events seen, holds at all-ones
//   ovf   out  1      set by any increment attempted at all-ones;
//                     cleared only by reset
module sat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] count_reg;
    logic             ovf_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (inc) begin
            if (&count_reg) begin
                // Already saturated: the event is lost, so remember that.
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + WIDTH'(1);
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/dial_zero_counter.sv
// Modular safe-dial walker that counts how often the dial hits zero.
//
// Commands (direction + step count) arrive over a valid/ready handshake.
// Each step moves the dial by one position, wrapping between DIAL_MAX and 0.
// Two results are tracked:
//   land_count - rotations whose final step leaves the dial on 0
//   pass_count - individual steps that arrive at 0 (landings included)
// With FAST_REV set, every whole revolution beyond the last one is retired in
// a single cycle; a full revolution always passes 0 exactly once and leaves
// the dial where it was.
//
// Ports:
//   clk             in   1            rising-edge clock
//   rst             in   1            asynchronous, active-low reset
//   in_valid        in   1            command present
//   in_ready        out  1            block is idle and can accept a command
//   step_direction  in   1            1 = up (+1/step), 0 = down (-1/step)
//   step_count      in   INPUT_WIDTH  number of steps, 0 allowed
//   busy            out  1            command in progress
//   dial_value      out  DIAL_WIDTH   current dial position
//   land_count      out  COUNT_WIDTH  rotations that ended on 0 (saturating)
//   pass_count      out  COUNT_WIDTH  steps that arrived at 0 (saturating)
//   land_ovf        out  1            sticky, land_count saturated
//   pass_ovf        out  1            sticky, pass_count saturated
//
// DIAL_INIT must not exceed DIAL_MAX.
module dial_zero_counter
    import dial_pkg::*;
#(
    parameter int INPUT_WIDTH = 10,
    parameter int COUNT_WIDTH = 12,
    parameter int DIAL_MAX    = 99,
    parameter int DIAL_INIT   = 50,
    parameter int FAST_REV    = 1,
    localparam int DIAL_WIDTH = $clog2(DIAL_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   step_direction,
    input  logic [INPUT_WIDTH-1:0] step_count,
    output logic                   busy,
    output logic [DIAL_WIDTH-1:0]  dial_value,
    output logic [COUNT_WIDTH-1:0] land_count,
    output logic [COUNT_WIDTH-1:0] pass_count,
    output logic                   land_ovf,
    output logic                   pass_ovf
);

    // Modulus as seen by the step counter, and dial limits in dial width.
    localparam logic [INPUT_WIDTH-1:0] N_EXT     = INPUT_WIDTH'(DIAL_MAX + 1);
    localparam logic [INPUT_WIDTH-1:0] ONE_EXT   = INPUT_WIDTH'(1);
    localparam logic [DIAL_WIDTH-1:0]  DIAL_TOP  = DIAL_WIDTH'(DIAL_MAX);
    localparam logic [DIAL_WIDTH-1:0]  DIAL_ZERO = '0;
    localparam logic [DIAL_WIDTH-1:0]  DIAL_RST  = DIAL_WIDTH'(DIAL_INIT);
    localparam logic                   FAST_EN   = (FAST_REV != 0);

    // Counter index map for the generated saturating counters.
    localparam int LAND_IDX = 0;
    localparam int PASS_IDX = 1;

    state_t                   state_reg,     state_next;
    logic [INPUT_WIDTH-1:0]   remaining_reg, remaining_next;
    logic                     dir_reg,       dir_next;
    logic [DIAL_WIDTH-1:0]    dial_reg,      dial_next;

    logic [DIAL_WIDTH-1:0]    step_pos;
    logic [1:0]               inc_vec;
    logic [COUNT_WIDTH-1:0]   count_vec [2];
    logic [1:0]               ovf_vec;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            dir_reg       <= DIR_DOWN;
            dial_reg      <= DIAL_RST;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            dial_reg      <= dial_next;
        end
    end

    // ------------------------------------------------------------------
    // Position after one step in the latched direction, with explicit wrap.
    // ------------------------------------------------------------------
    always_comb begin
        step_pos = dial_reg;
        if (dir_reg == DIR_UP) begin
            step_pos = (dial_reg == DIAL_TOP) ? DIAL_ZERO : dial_reg + DIAL_WIDTH'(1);
        end else begin
            step_pos = (dial_reg == DIAL_ZERO) ? DIAL_TOP : dial_reg - DIAL_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        dial_next      = dial_reg;
        inc_vec        = 2'b00;

        case (state_reg)
            IDLE: begin
                // A zero-step command is simply consumed: nothing latched,
                // no landing evaluated.
                if (in_valid && (step_count != '0)) begin
                    remaining_next = step_count;
                    dir_next       = step_direction;
                    // Strictly greater than N so that an exact last
                    // revolution is walked step by step and can land.
                    if (FAST_EN && (step_count > N_EXT)) begin
                        state_next = REV;
                    end else begin
                        state_next = STEP;
                    end
                end
            end

            REV: begin
                // A whole revolution crosses 0 once and returns the dial
                // to the same position.
                remaining_next    = remaining_reg - N_EXT;
                inc_vec[PASS_IDX] = 1'b1;
                state_next        = (remaining_next > N_EXT) ? REV : STEP;
            end

            STEP: begin
                dial_next      = step_pos;
                remaining_next = remaining_reg - ONE_EXT;
                if (step_pos == DIAL_ZERO) begin
                    inc_vec[PASS_IDX] = 1'b1;
                end
                if (remaining_reg == ONE_EXT) begin
                    inc_vec[LAND_IDX] = (step_pos == DIAL_ZERO);
                    state_next        = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result counters: index 0 = landings, index 1 = passes.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_counter
            sat_counter #(
                .WIDTH (COUNT_WIDTH)
            ) u_sat_counter (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc_vec[gi]),
                .count (count_vec[gi]),
                .ovf   (ovf_vec[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign dial_value = dial_reg;
    assign land_count = count_vec[LAND_IDX];
    assign pass_count = count_vec[PASS_IDX];
    assign land_ovf   = ovf_vec[LAND_IDX];
    assign pass_ovf   = ovf_vec[PASS_IDX];

endmodule

// File: tb/tb_dial_zero_counter.sv
// Directed testbench for dial_zero_counter.
// Instance 0: defaults (FAST_REV=1, COUNT_WIDTH=12)
// Instance 1: FAST_REV=0
// Instance 2: COUNT_WIDTH=4
module tb_dial_zero_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v   [3];
    logic       d   [3];
    logic [9:0] c   [3];
    logic       rdy [3];
    logic       bsy [3];
    logic [6:0] dial[3];
    logic       lovf[3];
    logic       povf[3];
    logic [11:0] land0, pass0, land1, pass1;
    logic [3:0]  land2, pass2;

    int tests_run    = 0;
    int tests_failed = 0;

    dial_zero_counter dut0 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy[0]),
        .step_direction(d[0]), .step_count(c[0]), .busy(bsy[0]),
        .dial_value(dial[0]), .land_count(land0), .pass_count(pass0),
        .land_ovf(lovf[0]), .pass_ovf(povf[0])
    );

    dial_zero_counter #(.FAST_REV(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy[1]),
        .step_direction(d[1]), .step_count(c[1]), .busy(bsy[1]),
        .dial_value(dial[1]), .land_count(land1), .pass_count(pass1),
        .land_ovf(lovf[1]), .pass_ovf(povf[1])
    );

    dial_zero_counter #(.COUNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(rdy[2]),
        .step_direction(d[2]), .step_count(c[2]), .busy(bsy[2]),
        .dial_value(dial[2]), .land_count(land2), .pass_count(pass2),
        .land_ovf(lovf[2]), .pass_ovf(povf[2])
    );

    // Stimulus helper: reset all instances, release #1 after a rising edge.
    task automatic apply_reset();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; d[i] = 1'b0; c[i] = '0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Stimulus helper: present one command to instance k, wait for its
    // acceptance, then count busy cycles until the instance is idle again.
    task automatic send(input int k, input logic dir, input logic [9:0] cnt,
                        output int cycles);
        int guard;
        d[k] = dir; c[k] = cnt; v[k] = 1'b1;
        guard = 0;
        while (!rdy[k] && guard < 5000) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 5000) begin
            tests_failed++;
            $display("FAIL accept_timeout inst=%0d: in_ready stayed %0d, required 1", k, rdy[k]);
        end
        @(posedge clk); #1;
        v[k] = 1'b0;
        cycles = 0;
        while (bsy[k] && cycles < 5000) begin
            @(posedge clk); #1; cycles++;
        end
        $display("[TB] inst=%0d cmd dir=%0d cnt=%0d busy_cycles=%0d dial=%0d", k, dir, cnt, cycles, dial[k]);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (dial[0] !== 7'd50) begin tests_failed++; $display("FAIL reset_dial: got %0d, required 50", dial[0]); end
        tests_run++; if (land0 !== 12'd0 || pass0 !== 12'd0) begin tests_failed++; $display("FAIL reset_counts: got land=%0d pass=%0d, required 0/0", land0, pass0); end
        tests_run++; if (lovf[0] !== 1'b0 || povf[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0d/%0d, required 0/0", lovf[0], povf[0]); end
        tests_run++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin tests_failed++; $display("FAIL reset_hs: got busy=%0d ready=%0d, required 0/1", bsy[0], rdy[0]); end
    endtask

    task automatic test_single_down();
        int cyc;
        apply_reset();
        send(0, 1'b0, 10'd68, cyc);
        tests_run++; if (cyc !== 68) begin tests_failed++; $display("FAIL d68_cycles: got %0d, required 68", cyc); end
        tests_run++; if (dial[0] !== 7'd82) begin tests_failed++; $display("FAIL d68_dial: got %0d, required 82", dial[0]); end
        tests_run++; if (pass0 !== 12'd1 || land0 !== 12'd0) begin tests_failed++; $display("FAIL d68_counts: got pass=%0d land=%0d, required 1/0", pass0, land0); end
        tests_run++; if (rdy[0] !== 1'b1) begin tests_failed++; $display("FAIL d68_ready: got %0d, required 1", rdy[0]); end
    endtask

    task automatic test_sequence();
        logic       sd [10];
        logic [9:0] sc [10];
        int guard;
        sd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sc = '{10'd68, 10'd30, 10'd48, 10'd5, 10'd60, 10'd55, 10'd1, 10'd99, 10'd14, 10'd82};
        apply_reset();
        v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d[0] = sd[i]; c[0] = sc[i];
            guard = 0;
            while (!rdy[0] && guard < 500) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
            $display("[TB] inst=0 seq cmd %0d dir=%0d cnt=%0d accepted", i, sd[i], sc[i]);
        end
        v[0] = 1'b0;
        guard = 0;
        while (bsy[0] && guard < 500) begin @(posedge clk); #1; guard++; end
        tests_run++; if (dial[0] !== 7'd32) begin tests_failed++; $display("FAIL seq_dial: got %0d, required 32", dial[0]); end
        tests_run++; if (land0 !== 12'd3) begin tests_failed++; $display("FAIL seq_land: got %0d, required 3", land0); end
        tests_run++; if (pass0 !== 12'd6) begin tests_failed++; $display("FAIL seq_pass: got %0d, required 6", pass0); end
    endtask

    task automatic test_fast_rev();
        int cyc;
        apply_reset();
        send(0, 1'b1, 10'd1000, cyc);
        tests_run++; if (cyc !== 109) begin tests_failed++; $display("FAIL fast_cycles: got %0d, required 109", cyc); end
        tests_run++; if (dial[0] !== 7'd50 || pass0 !== 12'd10 || land0 !== 12'd0) begin tests_failed++; $display("FAIL fast_result: got dial=%0d pass=%0d land=%0d, required 50/10/0", dial[0], pass0, land0); end
        send(1, 1'b1, 10'd1000, cyc);
        tests_run++; if (cyc !== 1000) begin tests_failed++; $display("FAIL slow_cycles: got %0d, required 1000", cyc); end
        tests_run++; if (dial[1] !== 7'd50 || pass1 !== 12'd10 || land1 !== 12'd0) begin tests_failed++; $display("FAIL slow_result: got dial=%0d pass=%0d land=%0d, required 50/10/0", dial[1], pass1, land1); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int guard;
        apply_reset();
        // U50, with a stray command presented while busy.
        d[0] = 1'b1; c[0] = 10'd50; v[0] = 1'b1;
        @(posedge clk); #1;
        d[0] = 1'b0; c[0] = 10'd5;
        repeat (10) begin @(posedge clk); #1; end
        v[0] = 1'b0;
        guard = 0;
        while (bsy[0] && guard < 500) begin @(posedge clk); #1; guard++; end
        $display("[TB] inst=0 cmd dir=1 cnt=50 (stray D5 while busy) dial=%0d", dial[0]);
        tests_run++; if (dial[0] !== 7'd0 || land0 !== 12'd1 || pass0 !== 12'd1) begin tests_failed++; $display("FAIL u50_result: got dial=%0d land=%0d pass=%0d, required 0/1/1", dial[0], land0, pass0); end
        send(0, 1'b1, 10'd100, cyc);
        tests_run++; if (cyc !== 100) begin tests_failed++; $display("FAIL u100_cycles: got %0d, required 100", cyc); end
        tests_run++; if (dial[0] !== 7'd0 || land0 !== 12'd2 || pass0 !== 12'd2) begin tests_failed++; $display("FAIL u100_result: got dial=%0d land=%0d pass=%0d, required 0/2/2", dial[0], land0, pass0); end
        send(0, 1'b0, 10'd0, cyc);
        tests_run++; if (cyc !== 0 || rdy[0] !== 1'b1) begin tests_failed++; $display("FAIL zero_hs: got cycles=%0d ready=%0d, required 0/1", cyc, rdy[0]); end
        tests_run++; if (dial[0] !== 7'd0 || land0 !== 12'd2 || pass0 !== 12'd2) begin tests_failed++; $display("FAIL zero_result: got dial=%0d land=%0d pass=%0d, required 0/2/2", dial[0], land0, pass0); end
    endtask

    task automatic test_reset_mid();
        int guard;
        apply_reset();
        d[0] = 1'b1; c[0] = 10'd300; v[0] = 1'b1;
        guard = 0;
        while (!rdy[0] && guard < 10) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        v[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        // Two REV cycles then two steps: dial 52, two passes.
        tests_run++; if (dial[0] !== 7'd52 || pass0 !== 12'd2 || bsy[0] !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got dial=%0d pass=%0d busy=%0d, required 52/2/1", dial[0], pass0, bsy[0]); end
        rst = 1'b0;
        #1;
        tests_run++; if (dial[0] !== 7'd50 || pass0 !== 12'd0 || land0 !== 12'd0 || bsy[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_abort: got dial=%0d pass=%0d land=%0d busy=%0d, required 50/0/0/0", dial[0], pass0, land0, bsy[0]); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("[TB] inst=0 cmd dir=1 cnt=300 aborted by reset dial=%0d", dial[0]);
        tests_run++; if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dial[0] !== 7'd50) begin tests_failed++; $display("FAIL mid_release: got ready=%0d busy=%0d dial=%0d, required 1/0/50", rdy[0], bsy[0], dial[0]); end
    endtask

    task automatic test_saturation();
        int cyc;
        apply_reset();
        send(2, 1'b1, 10'd50, cyc);
        for (int i = 0; i < 14; i++) send(2, 1'b1, 10'd100, cyc);
        tests_run++; if (land2 !== 4'd15 || pass2 !== 4'd15 || lovf[2] !== 1'b0 || povf[2] !== 1'b0) begin tests_failed++; $display("FAIL sat_edge: got land=%0d pass=%0d ovf=%0d/%0d, required 15/15/0/0", land2, pass2, lovf[2], povf[2]); end
        send(2, 1'b1, 10'd100, cyc);
        tests_run++; if (land2 !== 4'd15 || pass2 !== 4'd15 || lovf[2] !== 1'b1 || povf[2] !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf: got land=%0d pass=%0d ovf=%0d/%0d, required 15/15/1/1", land2, pass2, lovf[2], povf[2]); end
        send(2, 1'b0, 10'd7, cyc);
        tests_run++; if (land2 !== 4'd15 || lovf[2] !== 1'b1 || povf[2] !== 1'b1 || dial[2] !== 7'd93) begin tests_failed++; $display("FAIL sat_sticky: got land=%0d ovf=%0d/%0d dial=%0d, required 15/1/1/93", land2, lovf[2], povf[2], dial[2]); end
        apply_reset();
        tests_run++; if (land2 !== 4'd0 || pass2 !== 4'd0 || lovf[2] !== 1'b0 || povf[2] !== 1'b0) begin tests_failed++; $display("FAIL sat_clear: got land=%0d pass=%0d ovf=%0d/%0d, required 0/0/0/0", land2, pass2, lovf[2], povf[2]); end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; d[i] = 1'b0; c[i] = '0; end
        test_reset();
        test_single_down();
        test_sequence();
        test_fast_rev();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dial_zero_counter.md
Name: dial_zero_counter

Overview:
- Parametrised successor to the single-mode safe-dial zero counter.
- Consumes a stream of rotation commands (direction + step count) over a valid/ready handshake and walks a modular dial.
- Tracks two results at once:
  - landing count: the dial ends a rotation on 0.
  - pass count: the dial reaches 0 on any step, including landing.
- Optional fast path retires full revolutions one per cycle. Results saturate and raise sticky overflow flags. Sits between the input feeder and the result display logic.

Parameters:
- INPUT_WIDTH, 10, width of step_count.
- COUNT_WIDTH, 12, width of each result counter.
- DIAL_MAX, 99, highest dial position (inclusive); modulus N = DIAL_MAX+1.
- DIAL_INIT, 50, dial position after reset; must be <= DIAL_MAX.
- FAST_REV, 1, 1 = retire whole revolutions in one cycle each; 0 = single-step only.
- Local only: DIAL_WIDTH = clog2(N).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- step_direction  in  1  1 = up (+1 per step), 0 = down (-1 per step).
- step_count  in  INPUT_WIDTH  number of steps, 0 allowed.
- busy  out  1  command in progress (state != IDLE).
- dial_value  out  DIAL_WIDTH  current dial position.
- land_count  out  COUNT_WIDTH  rotations that ended on 0.
- pass_count  out  COUNT_WIDTH  steps that arrived at 0.
- land_ovf  out  1  sticky, land_count saturated.
- pass_ovf  out  1  sticky, pass_count saturated.

Behaviour:
- Reset (asynchronous, rst low):
  - state = IDLE, dial_value = DIAL_INIT.
  - Both counts = 0, both overflow flags = 0, busy = 0.
  - in_ready = 1 in the first cycle after release.
  - Asserting rst mid-command aborts the command with no partial retention.
- Handshake:
  - in_ready = (state == IDLE).
  - A command is accepted on a rising edge with in_valid && in_ready; it latches remaining <= step_count and dir <= step_direction.
  - in_valid while busy is ignored. The feeder holds the command until it is accepted.
- Acceptance routing:
  - step_count == 0: the command is consumed and the state stays IDLE. No dial change, no count change, landing is not evaluated.
  - FAST_REV && step_count > N: go to REV.
  - Otherwise (step_count >= 1): go to STEP.
- REV (one cycle per revolution):
  - remaining -= N, pass_count += 1 (saturating); dial unchanged.
  - Next state is REV while the new remaining > N, else STEP.
  - remaining == N is never consumed in REV, so a landing after an exact revolution is still detected.
- STEP (one cycle per step):
  - next = dir ? (dial == DIAL_MAX ? 0 : dial+1) : (dial == 0 ? DIAL_MAX : dial-1).
  - dial <= next, remaining -= 1.
  - If next == 0: pass_count += 1.
  - If remaining == 1: when next == 0, land_count += 1; then go to IDLE.
- Latency:
  - s <= N, or FAST_REV=0: exactly s busy cycles after the acceptance edge.
  - FAST_REV=1 and s > N: ceil((s-N)/N) REV cycles, then the remainder in STEP.
  - in_ready rises the cycle after the last STEP edge.
  - Back-to-back commands are allowed: a new command can be accepted on the edge where in_ready is high.
- Saturation: a counter at all-ones stays all-ones; an increment attempted at all-ones sets its ovf flag. Flags clear only on reset.
- Arithmetic: all dial math is in DIAL_WIDTH bits with explicit wrap as above; there is no modulo operator. remaining compares against N zero-extended to INPUT_WIDTH.

Decomposition:
- Shared package dial_pkg:
  - state enum {IDLE, REV, STEP}.
  - Direction constants DIR_UP = 1, DIR_DOWN = 0.
- One sub-module sat_counter (params WIDTH; ports clk, rst, inc, count, ovf), instantiated twice, for land and pass.

Test Plan (DIAL_MAX=99, DIAL_INIT=50, COUNT_WIDTH=12 unless noted):
- Single down 68 from reset -> dial 82, pass 1, land 0, busy exactly 68 cycles, in_ready high on cycle 69.
- Sequence D68, D30, U48, D5, U60, D55, D1, D99, U14, D82, with in_valid held continuously -> dial 32, land 3, pass 6.
- FAST_REV=1, U1000 from reset -> dial 50, pass 10, land 0, 9 REV cycles + 100 STEP cycles = 109 busy cycles. Same command with FAST_REV=0 -> identical results in 1000 cycles.
- U50 then U100 then step_count 0 -> after the first: dial 0, land 1, pass 1; after the second: land 2, pass 2; the zero-step command is consumed in one cycle with no change; in_valid during busy is ignored.
- Reset mid-command: accept U300, assert rst at busy cycle 5 -> dial 50, counts 0, busy 0; in_ready 1 after release.
- COUNT_WIDTH=4: U50 then 15 × U100 -> land = pass = 15, land_ovf = pass_ovf = 1. Flags stay set after further commands until reset.
